// File: rtl/fft_modulus_calc.sv
// Squared-magnitude stage: tags each FFT sample with its bin index and frame-last, 3-cycle latency.
// Backpressure: a stalled FIFO write (wr_en & !wr_vld) freezes every stage and drops s_ready.
module fft_modulus_calc #(
  parameter int DATA_W = 30,
  parameter int LOG2_N = 12,
  parameter int PWR_W  = 60   // must equal 2*DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_re,
  input  logic [DATA_W-1:0]        s_im,
  input  logic                     s_last,
  output logic                     wr_en,
  input  logic                     wr_vld,
  output logic [LOG2_N+PWR_W:0]    wr_data,
  output logic [15:0]              frame_cnt,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int OUT_W = 1 + LOG2_N + PWR_W;
  localparam logic [LOG2_N-1:0] IDX_MAX = '1;

  typedef struct packed {
    logic              last;
    logic [LOG2_N-1:0] idx;
    logic [PWR_W-1:0]  power;
  } wr_word_t;

  // Stage 1: captured sample
  logic                     v1_q, v1_d;
  logic signed [DATA_W-1:0] re1_q, re1_d, im1_q, im1_d;
  logic                     last1_q, last1_d;
  logic [LOG2_N-1:0]        idx1_q, idx1_d;
  // Stage 2: squares
  logic                     v2_q, v2_d;
  logic [PWR_W-1:0]         sq_re2_q, sq_re2_d, sq_im2_q, sq_im2_d;
  logic                     last2_q, last2_d;
  logic [LOG2_N-1:0]        idx2_q, idx2_d;
  // Stage 3: sum, presented to the FIFO
  logic                     v3_q, v3_d;
  logic [PWR_W-1:0]         pwr3_q, pwr3_d;
  logic                     last3_q, last3_d;
  logic [LOG2_N-1:0]        idx3_q, idx3_d;
  // Frame bookkeeping
  logic [LOG2_N-1:0]        idx_q, idx_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     frame_err_q, frame_err_d;

  logic en, accept, at_max, last_tag, wr_fire;
  logic signed [2*DATA_W-1:0] prod_re, prod_im;
  wr_word_t word;

  assign en       = ~v3_q | wr_vld;
  assign accept   = s_valid & en;
  assign at_max   = (idx_q == IDX_MAX);
  assign last_tag = s_last | at_max;
  assign wr_fire  = v3_q & wr_vld;

  // Squares are never negative, so the top product bit is always zero.
  assign prod_re = re1_q * re1_q;
  assign prod_im = im1_q * im1_q;

  always_comb begin
    v1_d        = v1_q;
    re1_d       = re1_q;
    im1_d       = im1_q;
    last1_d     = last1_q;
    idx1_d      = idx1_q;
    v2_d        = v2_q;
    sq_re2_d    = sq_re2_q;
    sq_im2_d    = sq_im2_q;
    last2_d     = last2_q;
    idx2_d      = idx2_q;
    v3_d        = v3_q;
    pwr3_d      = pwr3_q;
    last3_d     = last3_q;
    idx3_d      = idx3_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = accept & (s_last ^ at_max);

    if (en) begin
      v1_d     = accept;
      re1_d    = s_re;
      im1_d    = s_im;
      last1_d  = last_tag;
      idx1_d   = idx_q;

      v2_d     = v1_q;
      sq_re2_d = {1'b0, prod_re[2*DATA_W-2:0]};
      sq_im2_d = {1'b0, prod_im[2*DATA_W-2:0]};
      last2_d  = last1_q;
      idx2_d   = idx1_q;

      v3_d     = v2_q;
      pwr3_d   = sq_re2_q + sq_im2_q;
      last3_d  = last2_q;
      idx3_d   = idx2_q;
    end

    // A tagged last (explicit or forced at N-1) always restarts the bin count.
    if (accept) begin
      idx_d = last_tag ? '0 : idx_q + 1'b1;
    end

    if (wr_fire && last3_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      re1_q       <= '0;
      im1_q       <= '0;
      last1_q     <= 1'b0;
      idx1_q      <= '0;
      v2_q        <= 1'b0;
      sq_re2_q    <= '0;
      sq_im2_q    <= '0;
      last2_q     <= 1'b0;
      idx2_q      <= '0;
      v3_q        <= 1'b0;
      pwr3_q      <= '0;
      last3_q     <= 1'b0;
      idx3_q      <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      re1_q       <= re1_d;
      im1_q       <= im1_d;
      last1_q     <= last1_d;
      idx1_q      <= idx1_d;
      v2_q        <= v2_d;
      sq_re2_q    <= sq_re2_d;
      sq_im2_q    <= sq_im2_d;
      last2_q     <= last2_d;
      idx2_q      <= idx2_d;
      v3_q        <= v3_d;
      pwr3_q      <= pwr3_d;
      last3_q     <= last3_d;
      idx3_q      <= idx3_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    word.last  = last3_q;
    word.idx   = idx3_q;
    word.power = pwr3_q;
  end

  assign s_ready   = en;
  assign wr_en     = v3_q;
  assign wr_data   = OUT_W'(word);
  assign frame_cnt = frame_cnt_q;
  assign frame_err = frame_err_q;
  assign busy      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_fft_modulus_calc.sv
// Bench for fft_modulus_calc: directed vector table, frame corner cases and a randomized run
// against a per-sample arithmetic reference model.
module tb_fft_modulus_calc;

  localparam int DATA_W = 30;
  localparam int LOG2_N = 12;
  localparam int PWR_W  = 60;
  localparam int OUT_W  = 1 + LOG2_N + PWR_W;
  localparam int N      = 1 << LOG2_N;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     s_valid, s_ready, s_last;
  logic signed [DATA_W-1:0] s_re, s_im;
  logic                     wr_en, wr_vld;
  logic [OUT_W-1:0]         wr_data;
  logic [15:0]              frame_cnt;
  logic                     frame_err, busy;

  always #5 clk = ~clk;

  fft_modulus_calc #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .PWR_W(PWR_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .wr_en(wr_en), .wr_vld(wr_vld), .wr_data(wr_data),
    .frame_cnt(frame_cnt), .frame_err(frame_err), .busy(busy)
  );

  typedef struct { logic last; int idx; longint pwr; int acc; } word_t;
  typedef struct {
    logic signed [DATA_W-1:0] re, im;
    logic last;
    longint pwr;
    int idx;
    logic exp_last;
  } vec_t;

  word_t  exp_q[$];
  word_t  obs_q[$];
  vec_t   tbl[6];
  word_t  me, mo;
  longint mr, mi;

  int   tests = 0, fails = 0, cyc = 0;
  int   pos = 0, exp_fc = 0, err_pulses = 0;
  logic err_pend = 1'b0, prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  bit   chk_lat = 0, rec_obs = 0, rnd_done = 0;

  function automatic void check(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pos = 0; exp_fc = 0; err_pend = 1'b0; prev_stall = 1'b0;
    end else begin
      check("frame_err", frame_err, err_pend);
      if (frame_err) err_pulses++;
      err_pend = 1'b0;
      check("s_ready", s_ready, !wr_en || wr_vld);
      if (prev_stall) begin
        check("stall_wr_en", wr_en, 1);
        check("stall_data_stable", wr_data == prev_data, 1);
      end
      if (wr_en && wr_vld) begin
        mo.last = wr_data[OUT_W-1];
        mo.idx  = int'(wr_data[PWR_W +: LOG2_N]);
        mo.pwr  = longint'(wr_data[PWR_W-1:0]);
        mo.acc  = cyc;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: idx %0d with no sample outstanding", mo.idx);
        end else begin
          me = exp_q.pop_front();
          check("word_last", mo.last, me.last);
          check("word_idx", mo.idx, me.idx);
          check("word_power", mo.pwr, me.pwr);
          if (chk_lat) check("latency", cyc - me.acc, 3);
        end
        check("frame_cnt", frame_cnt, exp_fc);
        if (mo.last) exp_fc = (exp_fc + 1) % 65536;
        if (rec_obs) obs_q.push_back(mo);
      end
      prev_stall = wr_en && !wr_vld;
      prev_data  = wr_data;
      if (s_valid && s_ready) begin
        mr = s_re; mi = s_im;
        me.idx  = pos;
        me.last = s_last || (pos == N - 1);
        me.pwr  = mr * mr + mi * mi;
        me.acc  = cyc;
        err_pend = s_last != (pos == N - 1);
        pos = me.last ? 0 : pos + 1;
        exp_q.push_back(me);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im,
                      input logic last);
    bit acc = 0;
    int n = 0;
    s_valid = 1'b1; s_re = re; s_im = im; s_last = last;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = s_ready;
      n++;
      tick();
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: s_ready %0d, expected 1 within 1000 cycles", s_ready);
    end
  endtask

  task automatic send_rand(input logic last);
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    send(a[DATA_W-1:0], b[DATA_W-1:0], last);
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 1'b0; s_last = 1'b0; wr_vld = 1'b1;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0; wr_vld = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_s_ready", s_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data_zero", wr_data == '0, 1);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int e0, f0;
    s_valid = 1'b0; s_re = '0; s_im = '0; s_last = 1'b0; wr_vld = 1'b1;

    tbl[0] = '{re: 30'sd3,          im: -30'sd4,        last: 1'b0, pwr: 64'd25,
               idx: 0, exp_last: 1'b0};
    tbl[1] = '{re: 30'sh2000_0000,  im: 30'sh2000_0000, last: 1'b0, pwr: 64'd1 << 59,
               idx: 1, exp_last: 1'b0};
    tbl[2] = '{re: 30'sh1FFF_FFFF,  im: 30'sd0,         last: 1'b0,
               pwr: 64'd536870911 * 64'd536870911, idx: 2, exp_last: 1'b0};
    tbl[3] = '{re: 30'sd0,          im: -30'sd1,        last: 1'b0, pwr: 64'd1,
               idx: 3, exp_last: 1'b0};
    tbl[4] = '{re: -30'sd7,         im: 30'sd5,         last: 1'b1, pwr: 64'd74,
               idx: 4, exp_last: 1'b1};
    tbl[5] = '{re: 30'sd1,          im: 30'sd1,         last: 1'b0, pwr: 64'd2,
               idx: 0, exp_last: 1'b0};

    // Back-to-back vector table, fixed 3-cycle latency expected on every word.
    do_reset();
    obs_q.delete(); rec_obs = 1; chk_lat = 1;
    foreach (tbl[i]) send(tbl[i].re, tbl[i].im, tbl[i].last);
    drain();
    chk_lat = 0; rec_obs = 0;
    check("tbl_count", obs_q.size(), 6);
    foreach (tbl[i]) begin
      if (i < obs_q.size()) begin
        check("tbl_power", obs_q[i].pwr, tbl[i].pwr);
        check("tbl_idx", obs_q[i].idx, tbl[i].idx);
        check("tbl_last", obs_q[i].last, tbl[i].exp_last);
      end
    end
    check("tbl_frame_cnt", frame_cnt, 1);

    // Full well-formed frame.
    do_reset();
    e0 = err_pulses;
    obs_q.delete(); rec_obs = 1;
    for (int i = 0; i < N; i++) send(DATA_W'(i), '0, i == N - 1);
    drain();
    rec_obs = 0;
    check("full_count", obs_q.size(), N);
    if (obs_q.size() == N) begin
      check("full_last", obs_q[N-1].last, 1);
      check("full_idx", obs_q[N-1].idx, N - 1);
      check("full_power", obs_q[N-1].pwr, 64'd4095 * 64'd4095);
      check("full_mid_last", obs_q[N-2].last, 0);
    end
    check("full_frame_cnt", frame_cnt, 1);
    check("full_err_pulses", err_pulses - e0, 0);

    // Backpressure: FIFO refuses 5 cycles mid-stream.
    obs_q.delete(); rec_obs = 1;
    fork
      for (int i = 0; i < 20; i++) send_rand(1'b0);
      begin
        repeat (7) tick();
        wr_vld = 1'b0;
        repeat (5) tick();
        wr_vld = 1'b1;
      end
    join
    drain();
    rec_obs = 0;
    check("bp_count", obs_q.size(), 20);
    for (int i = 1; i < obs_q.size(); i++) check("bp_order", obs_q[i].idx, obs_q[i-1].idx + 1);

    // Early last at idx 99.
    do_reset();
    e0 = err_pulses;
    obs_q.delete(); rec_obs = 1;
    for (int i = 0; i < 101; i++) send_rand(i == 99);
    drain();
    rec_obs = 0;
    check("early_count", obs_q.size(), 101);
    if (obs_q.size() == 101) begin
      check("early_last", obs_q[99].last, 1);
      check("early_idx", obs_q[99].idx, 99);
      check("early_next_idx", obs_q[100].idx, 0);
    end
    check("early_err_pulses", err_pulses - e0, 1);
    check("early_frame_cnt", frame_cnt, 1);

    // Missing last: 4097 samples without s_last.
    do_reset();
    e0 = err_pulses;
    obs_q.delete(); rec_obs = 1;
    for (int i = 0; i < N + 1; i++) send_rand(1'b0);
    drain();
    rec_obs = 0;
    check("miss_count", obs_q.size(), N + 1);
    if (obs_q.size() == N + 1) begin
      check("miss_forced_last", obs_q[N-1].last, 1);
      check("miss_idx", obs_q[N-1].idx, N - 1);
      check("miss_wrap_idx", obs_q[N].idx, 0);
    end
    check("miss_err_pulses", err_pulses - e0, 1);
    check("miss_frame_cnt", frame_cnt, 1);

    // Reset mid-frame at idx 500 with the pipeline full.
    for (int i = 0; i < 499; i++) send_rand(1'b0);
    check("midrst_busy_before", busy, 1);
    check("midrst_wr_en_before", wr_en, 1);
    rst = 1'b1;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    s_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    obs_q.delete(); rec_obs = 1;
    send(30'sd5, 30'sd0, 1'b0);
    drain();
    rec_obs = 0;
    check("midrst_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("midrst_idx", obs_q[0].idx, 0);
      check("midrst_power", obs_q[0].pwr, 25);
    end

    // Randomized traffic with random input gaps and FIFO stalls.
    f0 = tests;
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 1500; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            tick();
          end
          send_rand($urandom_range(0, 149) == 0);
        end
        s_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          wr_vld = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    drain();
    check("rand_outstanding", exp_q.size(), 0);
    check("rand_checked", (tests - f0) > 1500, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at 5 ms, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/fft_modulus_calc.md
Name: fft_modulus_calc

Overview:
- Sits directly upstream of the FFT modulus FIFO (73-bit words, 4096 deep, prefetch type, single clock).
- Accepts the complex FFT output stream (signed re/im plus frame-last) and computes the squared magnitude re^2+im^2 in a 3-stage pipeline.
- Tags each result with its bin index and a last flag, and writes it into the FIFO through a stall-capable handshake.
- Also counts completed frames and flags malformed frames.

Parameters:
- DATA_W, 30: signed width of re/im inputs.
- LOG2_N, 12: log2 of FFT length; bin index width; N = 2^LOG2_N.
- PWR_W, 60: power field width. Fixed at 2*DATA_W; any other value is illegal.
- OUT_W, 73: derived localparam, 1+LOG2_N+PWR_W. Must equal the FIFO write width.

Ports:
- clk, in, 1: single system clock.
- rst, in, 1: asynchronous, active-high reset.
- s_valid, in, 1: input sample valid.
- s_ready, out, 1: block can accept a sample this cycle.
- s_re, in, DATA_W: signed real part.
- s_im, in, DATA_W: signed imaginary part.
- s_last, in, 1: last sample of FFT frame.
- wr_en, out, 1: FIFO write request.
- wr_vld, in, 1: FIFO can accept (not full); a write occurs when wr_en & wr_vld.
- wr_data, out, OUT_W: {last, bin_idx[LOG2_N-1:0], power[PWR_W-1:0]}.
- frame_cnt, out, 16: frames fully written to FIFO; wraps at 65535->0.
- frame_err, out, 1: one-cycle pulse on frame-length mismatch.
- busy, out, 1: any pipeline stage holds valid data.

Behaviour:
- Reset (async assert, registers cleared immediately), all outputs:
  - s_ready=1 (combinational, see below), wr_en=0, wr_data=0, frame_cnt=0, frame_err=0, busy=0.
  - All stage valids=0, bin index counter=0.
- Pipeline enable: en = !v3 | wr_vld, where v3 is the stage-3 valid. s_ready = en (combinational).
- Input acceptance: a sample is accepted when s_valid & s_ready.
- When en=0, every stage register holds; wr_en and wr_data stay stable until the write completes.
- Stage 1 (on en): register re, im, last_tag, idx; v1 <= accepted.
- Stage 2 (on en): sq_re = re*re, sq_im = im*im. Signed multiply, unsigned 2*DATA_W-1 result, zero-extended to PWR_W. v2 <= v1.
- Stage 3 (on en): power = sq_re + sq_im, PWR_W bits unsigned, cannot overflow (max 2^59 for DATA_W=30). v3 <= v2.
- Output mapping: wr_en = v3. wr_data = {last_tag, idx, power}.
- Latency: accepted sample to wr_en=1 is exactly 3 cycles with no stall; each stall cycle adds one.
- Throughput: 1 sample/cycle while wr_vld=1.
- Bin index counter:
  - Increments on each accepted sample.
  - last_tag = s_last | (idx==N-1).
  - When last_tag=1 on an accepted sample, the counter returns to 0.
  - Wrap: idx N-1 -> 0 always.
- Frame check:
  - On an accepted sample with s_last XOR (idx==N-1), frame_err pulses high the next cycle.
  - Early last: s_last at idx<N-1; frame is truncated, counter resets.
  - Missing last: idx==N-1 without s_last; the last tag is forced.
  - Data is still forwarded in both cases.
- frame_cnt increments by 1 on the cycle a word with last_tag=1 is written (wr_en & wr_vld).
- busy = v1|v2|v3.
- Simultaneous events: a stage-3 write and a new input acceptance in the same cycle are legal; the pipeline advances by one.
- Reset mid-frame: pipeline contents are discarded, and the next accepted sample is idx 0.

Test Plan:
- Streaming, no backpressure, wr_vld=1. Input re=3, im=-4, then re=-2^29, im=-2^29.
  - wr_en rises 3 cycles after acceptance.
  - First word's power=25, then power=2^59.
  - idx=0 then 1.
- Full frame: 4096 samples of re=i, im=0, s_last on the 4096th.
  - Word 4095 has last=1, idx=4095, power=4095^2.
  - frame_cnt 0->1; frame_err never pulses.
- Backpressure: wr_vld=0 for 5 cycles mid-stream while s_valid=1.
  - s_ready=0 once v3=1; wr_data stays stable.
  - No word lost or duplicated; output sequence equals input sequence.
- Early last: s_last at idx=99.
  - Word idx=99 has last=1; frame_err pulses once.
  - Next sample tagged idx=0; frame_cnt increments.
- Missing last: 4097 samples with no s_last.
  - Word idx=4095 has last=1 forced; frame_err pulses once.
  - Sample 4097 is tagged idx=0.
- Reset at idx=500 with 3 words in flight.
  - wr_en=0 and busy=0 immediately; frame_cnt=0.
  - First sample after release is tagged idx=0.
